coproc_xif_sched: RTL and testbench

In-order issue/commit/result scheduler for the custom coprocessor on the CV-X-IF. It sits between the core's X-interface (issue, commit, result channels) and the single-cycle custom execute stage. It buffers accepted offloaded instructions with their computed result and holds each one until the core commits or kills it. Committed results are returned in issue order on the result channel with valid/ready backpressure; killed entries are dropped silently.

---
 rtl/coproc_xif_sched_if.sv | 37 +++
 rtl/coproc_xif_sched.sv | 140 ++++++++++++++
 tb/tb_coproc_xif_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_xif_sched_if.sv
// X-interface channel bundle between the core (master) and the coprocessor scheduler (slave).
// Signal names keep the scheduler-side _i/_o direction suffixes.
interface coproc_xif_sched_if #(
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
);
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic [4:0]          issue_rd_i;
  logic                ex_accept_i;
  logic [XLEN-1:0]     ex_result_i;
  logic                issue_accept_o;
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [XLEN-1:0]     result_data_o;
  logic [4:0]          result_rd_o;
  logic                result_we_o;

  modport master (
    output issue_valid_i, issue_id_i, issue_rd_i, ex_accept_i, ex_result_i,
    output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_id_i, issue_rd_i, ex_accept_i, ex_result_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/coproc_xif_sched.sv
// In-order issue/commit/result scheduler for the CV-X-IF custom coprocessor.
// Optional perf counters: define COPROC_SCHED_PERF_EN.
module coproc_xif_sched #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  coproc_xif_sched_if.slave xif,
  output logic              err_unknown_id_o,
  output logic [31:0]       issued_cnt_o,
  output logic [31:0]       killed_cnt_o
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [1:0]  ST_PEND   = 2'd0;
  localparam logic [1:0]  ST_COMMIT = 2'd1;
  localparam logic [1:0]  ST_KILL   = 2'd2;

  logic [DEPTH-1:0]    r_valid;
  logic [1:0]          r_state [DEPTH];
  logic [ID_WIDTH-1:0] r_id    [DEPTH];
  logic [4:0]          r_rd    [DEPTH];
  logic [XLEN-1:0]     r_data  [DEPTH];
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [PW:0]         r_count;
  logic                r_err;

  logic             w_id_hit;
  logic             w_cmt_hit;
  logic [DEPTH-1:0] w_cmt_apply;
  logic             w_ready;
  logic             w_push;
  logic             w_push_match;
  logic             w_pop;
  logic             w_head_commit;
  logic             w_head_kill;
  logic             w_kill_applied;
  logic [1:0]       w_cmt_state;

  // Associative lookup of issue and commit ids against held entries.
  always_comb begin
    w_id_hit    = 1'b0;
    w_cmt_hit   = 1'b0;
    w_cmt_apply = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_id_hit       = w_id_hit | (r_valid[i] & (r_id[i] == xif.issue_id_i));
      w_cmt_hit      = w_cmt_hit | (xif.commit_valid_i & r_valid[i] & (r_id[i] == xif.commit_id_i));
      w_cmt_apply[i] = xif.commit_valid_i & r_valid[i] & (r_id[i] == xif.commit_id_i)
                       & (r_state[i] == ST_PEND);
    end
  end

  assign w_ready        = (r_count < CNT_FULL) & ~w_id_hit;
  assign w_push         = xif.issue_valid_i & w_ready & xif.ex_accept_i;
  assign w_push_match   = xif.commit_valid_i & w_push & ~w_cmt_hit
                          & (xif.commit_id_i == xif.issue_id_i);
  assign w_cmt_state    = xif.commit_kill_i ? ST_KILL : ST_COMMIT;
  assign w_head_commit  = r_valid[r_head] & (r_state[r_head] == ST_COMMIT);
  assign w_head_kill    = r_valid[r_head] & (r_state[r_head] == ST_KILL);
  assign w_pop          = w_head_kill | (w_head_commit & xif.result_ready_i);
  assign w_kill_applied = xif.commit_valid_i & xif.commit_kill_i & ((|w_cmt_apply) | w_push_match);

  assign xif.issue_ready_o  = w_ready;
  assign xif.issue_accept_o = w_ready & xif.ex_accept_i;

  // Result channel is a pure function of the head entry registers.
  assign xif.result_valid_o = w_head_commit;
  assign xif.result_we_o    = w_head_commit;
  assign xif.result_id_o    = w_head_commit ? r_id[r_head]   : {ID_WIDTH{1'b0}};
  assign xif.result_data_o  = w_head_commit ? r_data[r_head] : {XLEN{1'b0}};
  assign xif.result_rd_o    = w_head_commit ? r_rd[r_head]   : 5'd0;
  assign err_unknown_id_o   = r_err;

  // Entry storage: commit/kill marking, head retirement, tail allocation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_PEND;
        r_id[i]    <= '0;
        r_rd[i]    <= 5'd0;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_cmt_apply[i]) r_state[i] <= w_cmt_state;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      // A commit arriving with its own issue lands directly in the new entry.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_state[r_tail] <= w_push_match ? w_cmt_state : ST_PEND;
        r_id[r_tail]    <= xif.issue_id_i;
        r_rd[r_tail]    <= xif.issue_rd_i;
        r_data[r_tail]  <= xif.ex_result_i;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PW+1)'(1);
      end
      if (xif.commit_valid_i && !w_cmt_hit && !w_push_match) r_err <= 1'b1;
    end
  end

`ifdef COPROC_SCHED_PERF_EN
  logic [31:0] r_issued_cnt;
  logic [31:0] r_killed_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issued_cnt <= 32'd0;
      r_killed_cnt <= 32'd0;
    end else begin
      if (w_push && (r_issued_cnt != 32'hFFFF_FFFF)) r_issued_cnt <= r_issued_cnt + 32'd1;
      if (w_kill_applied && (r_killed_cnt != 32'hFFFF_FFFF)) r_killed_cnt <= r_killed_cnt + 32'd1;
    end
  end

  assign issued_cnt_o = r_issued_cnt;
  assign killed_cnt_o = r_killed_cnt;
`else
  logic w_unused_kill;
  assign w_unused_kill = w_kill_applied;
  assign issued_cnt_o  = 32'd0;
  assign killed_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_coproc_xif_sched.sv
// Scoreboard bench for coproc_xif_sched: queue-based reference model plus decoupled result monitor.
module tb_coproc_xif_sched;
  localparam int DEPTH = 4;
  localparam int ST_P = 0;
  localparam int ST_C = 1;
  localparam int ST_K = 2;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    int          st;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        err_o;
  logic [31:0] issued_o;
  logic [31:0] killed_o;

  coproc_xif_sched_if #(.ID_WIDTH(4), .XLEN(32)) xif ();

  coproc_xif_sched #(.DEPTH(DEPTH), .ID_WIDTH(4), .XLEN(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .xif              (xif),
    .err_unknown_id_o (err_o),
    .issued_cnt_o     (issued_o),
    .killed_cnt_o     (killed_o)
  );

  always #5 clk = ~clk;

  ent_t mq[$];     // entries the scheduler should be holding, oldest first
  ent_t exp_q[$];  // results expected on the result channel, in order
  bit   m_err;
  int   m_issued;
  int   m_killed;
  int   n_tests;
  int   n_fail;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit held(logic [3:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit head_committed();
    return (mq.size() > 0) && (mq[0].st == ST_C);
  endfunction

  task automatic check_counters();
`ifdef COPROC_SCHED_PERF_EN
    chk("issued_cnt", issued_o, 32'(m_issued));
    chk("killed_cnt", killed_o, 32'(m_killed));
`else
    chk("issued_cnt_off", issued_o, 32'd0);
    chk("killed_cnt_off", killed_o, 32'd0);
`endif
  endtask

  // One clock of stimulus; the model advances by the scheduler's rules.
  task automatic cycle(input logic iv, input logic [3:0] iid, input logic [4:0] ird,
                       input logic acc, input logic [31:0] res, input logic cv,
                       input logic [3:0] cid, input logic ck, input logic rr);
    bit exp_ready, do_push, do_pop, found;
    int pst;
    @(negedge clk);
    xif.issue_valid_i  = iv;
    xif.issue_id_i     = iid;
    xif.issue_rd_i     = ird;
    xif.ex_accept_i    = acc;
    xif.ex_result_i    = res;
    xif.commit_valid_i = cv;
    xif.commit_id_i    = cid;
    xif.commit_kill_i  = ck;
    xif.result_ready_i = rr;
    #1;
    exp_ready = (mq.size() < DEPTH) && !held(iid);
    chk("issue_ready", 32'(xif.issue_ready_o), 32'(exp_ready));
    chk("issue_accept", 32'(xif.issue_accept_o), 32'(exp_ready && acc));
    chk("result_valid", 32'(xif.result_valid_o), 32'(head_committed()));
    chk("err_unknown_id", 32'(err_o), 32'(m_err));
    check_counters();
    do_pop  = (mq.size() > 0) && ((mq[0].st == ST_K) || ((mq[0].st == ST_C) && rr));
    do_push = iv && exp_ready && acc;
    if (do_pop && (mq[0].st == ST_C)) exp_q.push_back(mq[0]);
    pst = ST_P;
    if (cv) begin
      found = 1'b0;
      foreach (mq[i]) begin
        if (mq[i].id == cid) begin
          found = 1'b1;
          if (mq[i].st == ST_P) begin
            mq[i].st = ck ? ST_K : ST_C;
            if (ck) m_killed++;
          end
        end
      end
      if (!found && do_push && (cid == iid)) begin
        found = 1'b1;
        pst = ck ? ST_K : ST_C;
        if (ck) m_killed++;
      end
      if (!found) m_err = 1'b1;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back('{id: iid, rd: ird, data: res, st: pst});
      m_issued++;
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, rr);
  endtask

  task automatic issue(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d);
    cycle(1'b1, id, rd, 1'b1, d, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic commit(input logic [3:0] id, input logic k, input logic rr);
    cycle(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, 1'b1, id, k, rr);
  endtask

  // Commit whatever is still pending and let every result leave.
  task automatic drain(input int n);
    logic [3:0] cid;
    bit have;
    for (int k = 0; k < n; k++) begin
      have = 1'b0;
      cid  = 4'd0;
      foreach (mq[i]) if (!have && (mq[i].st == ST_P)) begin have = 1'b1; cid = mq[i].id; end
      cycle(1'b0, 4'd0, 5'd0, 1'b0, 32'd0, have, cid, 1'b0, 1'b1);
    end
    chk("drained_model", 32'(mq.size()), 32'd0);
    chk("drained_results", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    xif.issue_valid_i  = 1'b0;
    xif.ex_accept_i    = 1'b0;
    xif.commit_valid_i = 1'b0;
    xif.result_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_issue_ready", 32'(xif.issue_ready_o), 32'd1);
    chk("rst_issue_accept", 32'(xif.issue_accept_o), 32'd0);
    chk("rst_result_valid", 32'(xif.result_valid_o), 32'd0);
    chk("rst_result_id", 32'(xif.result_id_o), 32'd0);
    chk("rst_result_data", xif.result_data_o, 32'd0);
    chk("rst_result_rd", 32'(xif.result_rd_o), 32'd0);
    chk("rst_result_we", 32'(xif.result_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_issued_cnt", issued_o, 32'd0);
    chk("rst_killed_cnt", killed_o, 32'd0);
    mq.delete();
    exp_q.delete();
    m_err = 1'b0;
    m_issued = 0;
    m_killed = 0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic run_random(input int n);
    logic [3:0] pend[$];
    logic [3:0] cid;
    for (int c = 0; c < n; c++) begin
      pend.delete();
      foreach (mq[i]) if (mq[i].st == ST_P) pend.push_back(mq[i].id);
      if ((pend.size() > 0) && ($urandom_range(0, 7) != 0))
        cid = pend[$urandom_range(0, pend.size() - 1)];
      else
        cid = 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 4) != 0), $urandom, 1'($urandom_range(0, 2) != 0), cid,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  // Result monitor: pops the scoreboard on each handshake and checks hold-stability.
  initial begin
    bit          hold = 1'b0;
    logic [3:0]  h_id;
    logic [31:0] h_data;
    logic [4:0]  h_rd;
    ent_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni && xif.result_valid_o) begin
        if (hold) begin
          chk("hold_id", 32'(xif.result_id_o), 32'(h_id));
          chk("hold_data", xif.result_data_o, h_data);
          chk("hold_rd", 32'(xif.result_rd_o), 32'(h_rd));
        end
        if (xif.result_ready_i) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            chk("result_unexpected_id", 32'(xif.result_id_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("result_id", 32'(xif.result_id_o), 32'(e.id));
            chk("result_data", xif.result_data_o, e.data);
            chk("result_rd", 32'(xif.result_rd_o), 32'(e.rd));
            chk("result_we", 32'(xif.result_we_o), 32'd1);
          end
        end else begin
          hold   = 1'b1;
          h_id   = xif.result_id_o;
          h_data = xif.result_data_o;
          h_rd   = xif.result_rd_o;
        end
      end else begin
        if (rst_ni && hold) chk("hold_valid_dropped", 32'(xif.result_valid_o), 32'd1);
        hold = 1'b0;
      end
    end
  end

  initial begin
    xif.issue_valid_i  = 1'b0;
    xif.issue_id_i     = 4'd0;
    xif.issue_rd_i     = 5'd0;
    xif.ex_accept_i    = 1'b0;
    xif.ex_result_i    = 32'd0;
    xif.commit_valid_i = 1'b0;
    xif.commit_id_i    = 4'd0;
    xif.commit_kill_i  = 1'b0;
    xif.result_ready_i = 1'b0;
    n_tests = 0;
    n_fail  = 0;
    do_reset();

    // single op: result visible two cycles after the issue
    issue(4'd3, 5'd5, 32'h0000_1234);
    commit(4'd3, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("single_done", 32'(exp_q.size() + mq.size()), 32'd0);

    // reject
    cycle(1'b1, 4'd4, 5'd1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("reject_empty", 32'(mq.size()), 32'd0);

    // kill and order
    issue(4'd1, 5'd11, 32'h1111_0001);
    issue(4'd2, 5'd12, 32'h2222_0002);
    issue(4'd3, 5'd13, 32'h3333_0003);
    commit(4'd2, 1'b1, 1'b1);
    commit(4'd3, 1'b0, 1'b1);
    commit(4'd1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // full with backpressure, then a full-and-popping cycle
    issue(4'd10, 5'd1, 32'hA0);
    issue(4'd11, 5'd2, 32'hA1);
    issue(4'd12, 5'd3, 32'hA2);
    issue(4'd13, 5'd4, 32'hA3);
    for (int i = 10; i < 14; i++) commit(4'(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 4'd14, 5'd6, 1'b1, 32'hA4, 1'b0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 4'd14, 5'd6, 1'b1, 32'hA4, 1'b1, 4'd14, 1'b0, 1'b0);
    drain(12);

    // same-cycle issue and commit, then an unknown id
    cycle(1'b1, 4'd7, 5'd9, 1'b1, 32'h0777_0777, 1'b1, 4'd7, 1'b0, 1'b1);
    idle(2, 1'b1);
    commit(4'd9, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("err_sticky", 32'(err_o), 32'd1);
    do_reset();

    // perf: 5 accepted issues, 2 kills
    issue(4'd1, 5'd1, 32'h1);
    issue(4'd2, 5'd2, 32'h2);
    issue(4'd3, 5'd3, 32'h3);
    commit(4'd2, 1'b1, 1'b1);
    commit(4'd1, 1'b0, 1'b1);
    commit(4'd3, 1'b0, 1'b1);
    drain(6);
    issue(4'd4, 5'd4, 32'h4);
    cycle(1'b1, 4'd5, 5'd5, 1'b1, 32'h5, 1'b1, 4'd5, 1'b1, 1'b1);
    drain(6);
    idle(1, 1'b1);
`ifdef COPROC_SCHED_PERF_EN
    chk("perf_issued_5", issued_o, 32'd5);
    chk("perf_killed_2", killed_o, 32'd2);
`else
    chk("perf_issued_off", issued_o, 32'd0);
    chk("perf_killed_off", killed_o, 32'd0);
`endif
    // reset mid-stream with committed results waiting
    issue(4'd6, 5'd6, 32'h6);
    commit(4'd6, 1'b0, 1'b0);
    do_reset();
    idle(3, 1'b1);

    run_random(3000);
    drain(40);
    run_random(1500);
    drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
